// File: rtl/fpu_share_arbiter.sv
// Two-core arbiter in front of one shared FPU: grants one operation at a time,
// launches it, waits for the result (or a timeout) and returns it to its owner.
module fpu_share_arbiter #(
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid_0,
  output logic        req_ready_0,
  input  logic [4:0]  req_op_0,
  input  logic [31:0] req_a_0,
  input  logic [31:0] req_b_0,
  input  logic [4:0]  req_rd_0,
  input  logic        req_valid_1,
  output logic        req_ready_1,
  input  logic [4:0]  req_op_1,
  input  logic [31:0] req_a_1,
  input  logic [31:0] req_b_1,
  input  logic [4:0]  req_rd_1,
  output logic        rsp_valid_0,
  input  logic        rsp_ready_0,
  output logic        rsp_valid_1,
  input  logic        rsp_ready_1,
  output logic [31:0] rsp_data,
  output logic [4:0]  rsp_rd,
  output logic        rsp_err,
  output logic        fpu_start,
  output logic [4:0]  fpu_op,
  output logic [31:0] fpu_a,
  output logic [31:0] fpu_b,
  input  logic        fpu_done,
  input  logic [31:0] fpu_result
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t           state, state_nxt;
  logic             prio, owner;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             grant0, grant1, accept, cnt_hit, rsp_ready_own;
  logic [4:0]       sel_op, sel_rd;
  logic [31:0]      sel_a, sel_b;

  // Opcode 5'b01011 is a hole in the FPUControl map; everything above 5'b10010 is unused.
  function automatic logic op_legal(input logic [4:0] op);
    logic ok;
    case (op)
      5'b01011: ok = 1'b0;
      default:  ok = (op <= 5'b10010);
    endcase
    return ok;
  endfunction

  assign sel_op        = grant1 ? req_op_1 : req_op_0;
  assign sel_rd        = grant1 ? req_rd_1 : req_rd_0;
  assign sel_a         = grant1 ? req_a_1  : req_a_0;
  assign sel_b         = grant1 ? req_b_1  : req_b_0;
  assign accept        = grant0 | grant1;
  assign cnt_nxt       = cnt + CNT_W'(1);
  assign cnt_hit       = (cnt_nxt == CNT_W'(TIMEOUT));
  assign rsp_ready_own = owner ? rsp_ready_1 : rsp_ready_0;

  assign req_ready_0   = grant0;
  assign req_ready_1   = grant1;
  assign fpu_start     = (state == ISSUE) & ~rst;
  assign rsp_valid_0   = (state == RESP) & ~owner & ~rst;
  assign rsp_valid_1   = (state == RESP) &  owner & ~rst;

  always_comb begin
    grant0    = 1'b0;
    grant1    = 1'b0;
    state_nxt = state;
    case (state)
      IDLE: begin
        if (!rst) begin
          if (req_valid_0 && (!req_valid_1 || !prio)) grant0 = 1'b1;
          else if (req_valid_1)                       grant1 = 1'b1;
        end
        if (grant0 || grant1) state_nxt = op_legal(sel_op) ? ISSUE : RESP;
      end
      ISSUE: state_nxt = WAIT;
      WAIT:  if (fpu_done || cnt_hit) state_nxt = RESP;
      RESP:  if (rsp_ready_own) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      prio     <= 1'b0;
      owner    <= 1'b0;
      cnt      <= '0;
      fpu_op   <= '0;
      fpu_a    <= '0;
      fpu_b    <= '0;
      rsp_data <= '0;
      rsp_rd   <= '0;
      rsp_err  <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (accept) begin
            owner    <= grant1;
            fpu_op   <= sel_op;
            fpu_a    <= sel_a;
            fpu_b    <= sel_b;
            rsp_rd   <= sel_rd;
            rsp_data <= '0;
            rsp_err  <= ~op_legal(sel_op);
          end
        end
        ISSUE: cnt <= '0;
        WAIT: begin
          cnt <= cnt_nxt;
          // A result arriving on the timeout cycle still counts as on time.
          if (fpu_done) begin
            rsp_data <= fpu_result;
            rsp_err  <= 1'b0;
          end else if (cnt_hit) begin
            rsp_data <= 32'hFFFF_FFFF;
            rsp_err  <= 1'b1;
          end
        end
        RESP: if (rsp_ready_own) prio <= ~owner;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_share_arbiter.sv
// Directed bench for fpu_share_arbiter: a cycle-count transaction model is
// checked against the DUT every cycle, plus literal latency/data expectations.
module tb_fpu_share_arbiter;

  localparam int TIMEOUT = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid_0, req_ready_0, req_valid_1, req_ready_1;
  logic [4:0]  req_op_0, req_rd_0, req_op_1, req_rd_1;
  logic [31:0] req_a_0, req_b_0, req_a_1, req_b_1;
  logic        rsp_valid_0, rsp_ready_0, rsp_valid_1, rsp_ready_1;
  logic [31:0] rsp_data;
  logic [4:0]  rsp_rd;
  logic        rsp_err;
  logic        fpu_start, fpu_done;
  logic [4:0]  fpu_op;
  logic [31:0] fpu_a, fpu_b, fpu_result;

  fpu_share_arbiter #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .req_valid_0(req_valid_0), .req_ready_0(req_ready_0), .req_op_0(req_op_0),
    .req_a_0(req_a_0), .req_b_0(req_b_0), .req_rd_0(req_rd_0),
    .req_valid_1(req_valid_1), .req_ready_1(req_ready_1), .req_op_1(req_op_1),
    .req_a_1(req_a_1), .req_b_1(req_b_1), .req_rd_1(req_rd_1),
    .rsp_valid_0(rsp_valid_0), .rsp_ready_0(rsp_ready_0),
    .rsp_valid_1(rsp_valid_1), .rsp_ready_1(rsp_ready_1),
    .rsp_data(rsp_data), .rsp_rd(rsp_rd), .rsp_err(rsp_err),
    .fpu_start(fpu_start), .fpu_op(fpu_op), .fpu_a(fpu_a), .fpu_b(fpu_b),
    .fpu_done(fpu_done), .fpu_result(fpu_result)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int n_start = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit legal(input logic [4:0] op);
    int v;
    v = int'(op);
    return (v <= 10) || (v >= 12 && v <= 18);
  endfunction

  // Transaction model: one operation in flight, timed by cycle numbers.
  int          cyc = 0;
  bit          m_busy = 0, m_owner = 0, m_illegal = 0, m_prio = 0, m_fresh = 0, m_have_rsp = 0;
  int          m_acc = 0, m_rsp_at = 0;
  logic [4:0]  m_op = '0, m_rd = '0;
  logic [31:0] m_a = '0, m_b = '0, m_data = '0;
  logic        m_err = 1'b0;

  always @(negedge clk) begin
    bit g0, g1, rv, st;
    if (fpu_start) n_start++;
    g0 = !m_busy && req_valid_0 && (!req_valid_1 || !m_prio);
    g1 = !m_busy && req_valid_1 && !g0;
    st = !rst && m_busy && !m_illegal && (cyc == m_acc + 1);
    rv = !rst && m_busy && m_have_rsp && (cyc >= m_rsp_at);
    chk("req_ready_0", 32'(req_ready_0), 32'(!rst && g0));
    chk("req_ready_1", 32'(req_ready_1), 32'(!rst && g1));
    chk("fpu_start",   32'(fpu_start),   32'(st));
    chk("rsp_valid_0", 32'(rsp_valid_0), 32'(rv && !m_owner));
    chk("rsp_valid_1", 32'(rsp_valid_1), 32'(rv && m_owner));
    if (rv || (m_fresh && !m_busy)) begin
      chk("rsp_data", rsp_data, m_data);
      chk("rsp_rd",   32'(rsp_rd),  32'(m_rd));
      chk("rsp_err",  32'(rsp_err), 32'(m_err));
    end
    if (m_busy || m_fresh) begin
      chk("fpu_op", 32'(fpu_op), 32'(m_op));
      chk("fpu_a",  fpu_a, m_a);
      chk("fpu_b",  fpu_b, m_b);
    end
    if (rst) begin
      m_busy = 0; m_prio = 0; m_fresh = 1; m_have_rsp = 0;
      m_op = '0; m_a = '0; m_b = '0; m_data = '0; m_rd = '0; m_err = 1'b0;
    end else if (!m_busy) begin
      if (g0 || g1) begin
        m_busy = 1; m_fresh = 0; m_owner = g1; m_acc = cyc;
        m_op = g1 ? req_op_1 : req_op_0;
        m_a  = g1 ? req_a_1  : req_a_0;
        m_b  = g1 ? req_b_1  : req_b_0;
        m_rd = g1 ? req_rd_1 : req_rd_0;
        m_illegal = !legal(m_op);
        m_have_rsp = m_illegal;
        m_rsp_at = cyc + 1;
        m_data = '0;
        m_err = m_illegal;
      end
    end else if (!m_have_rsp) begin
      if (cyc >= m_acc + 2 && fpu_done) begin
        m_have_rsp = 1; m_rsp_at = cyc + 1; m_data = fpu_result; m_err = 1'b0;
      end else if (cyc == m_acc + 1 + TIMEOUT) begin
        m_have_rsp = 1; m_rsp_at = cyc + 1; m_data = 32'hFFFF_FFFF; m_err = 1'b1;
      end
    end else if (cyc >= m_rsp_at && (m_owner ? rsp_ready_1 : rsp_ready_0)) begin
      m_busy = 0; m_prio = !m_owner;
    end
    cyc++;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_grant(output int core, output time t);
    core = -1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (req_ready_0) begin core = 0; break; end
      if (req_ready_1) begin core = 1; break; end
    end
    t = $time;
    if (core < 0) begin
      checks++; errors++;
      $display("FAIL grant_timeout: got none expected a grant at %0t", $time);
    end
    step(1);
    if (core == 0) req_valid_0 = 1'b0;
    if (core == 1) req_valid_1 = 1'b0;
  endtask

  task automatic serve(input int lat, input logic [31:0] res);
    bit found;
    found = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (fpu_start) begin found = 1; break; end
    end
    if (!found) begin
      checks++; errors++;
      $display("FAIL start_timeout: got no fpu_start expected one at %0t", $time);
    end else begin
      step(lat);
      fpu_done = 1'b1; fpu_result = res;
      step(1);
      fpu_done = 1'b0; fpu_result = 32'hDEAD_BEEF;
    end
  endtask

  task automatic wait_rsp(input int c, output time t);
    bit found;
    found = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if ((c == 0) ? rsp_valid_0 : rsp_valid_1) begin found = 1; break; end
    end
    t = $time;
    if (!found) begin
      checks++; errors++;
      $display("FAIL rsp_timeout: got no rsp_valid_%0d expected one at %0t", c, $time);
    end
  endtask

  task automatic consume(input int c);
    step(1);
    if (c == 0) rsp_ready_0 = 1'b1; else rsp_ready_1 = 1'b1;
    step(1);
    rsp_ready_0 = 1'b0; rsp_ready_1 = 1'b0;
  endtask

  task automatic set_req(input int c, input logic [4:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd);
    if (c == 0) begin req_op_0 = op; req_a_0 = a; req_b_0 = b; req_rd_0 = rd; req_valid_0 = 1'b1; end
    else        begin req_op_1 = op; req_a_1 = a; req_b_1 = b; req_rd_1 = rd; req_valid_1 = 1'b1; end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no end expected $finish at %0t", $time);
    $fatal(1);
  end

  initial begin
    int core;
    time t0, t1;
    logic [4:0] ops [5];
    ops = '{5'b11111, 5'b10011, 5'b10010, 5'b01100, 5'b01010};
    rst = 1'b1; fpu_done = 1'b0; fpu_result = '0;
    req_valid_0 = 1'b0; req_op_0 = '0; req_a_0 = '0; req_b_0 = '0; req_rd_0 = '0;
    req_valid_1 = 1'b0; req_op_1 = '0; req_a_1 = '0; req_b_1 = '0; req_rd_1 = '0;
    rsp_ready_0 = 1'b0; rsp_ready_1 = 1'b0;
    step(2);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_rsp_data", rsp_data, 32'h0);
    chk("reset_fpu_op", 32'(fpu_op), 32'h0);
    step(1);

    // Single FMUL on core 0
    n_start = 0;
    set_req(0, 5'b00010, 32'h4000_0000, 32'h4040_0000, 5'd5);
    wait_grant(core, t0);
    chk("fmul_grant", 32'(core), 32'd0);
    serve(3, 32'h40C0_0000);
    wait_rsp(0, t1);
    chk("fmul_latency", 32'((t1 - t0) / 10), 32'd5);
    chk("fmul_data", rsp_data, 32'h40C0_0000);
    chk("fmul_rd", 32'(rsp_rd), 32'd5);
    chk("fmul_err", 32'(rsp_err), 32'd0);
    consume(0);
    chk("fmul_starts", 32'(n_start), 32'd1);

    // Contention from reset, priority alternation
    rst = 1'b1;
    set_req(0, 5'b00001, 32'h3F80_0000, 32'h4000_0000, 5'd3);
    set_req(1, 5'b00000, 32'h3F80_0000, 32'h3F80_0000, 5'd7);
    step(2);
    rst = 1'b0;
    wait_grant(core, t0);
    chk("cont_first", 32'(core), 32'd0);
    serve(2, 32'h4040_0000);
    wait_rsp(0, t1);
    consume(0);
    wait_grant(core, t0);
    chk("cont_second", 32'(core), 32'd1);
    serve(1, 32'h4000_0000);
    wait_rsp(1, t1);
    consume(1);
    set_req(0, 5'b00100, 32'h1111_1111, 32'h2222_2222, 5'd1);
    set_req(1, 5'b00101, 32'h3333_3333, 32'h4444_4444, 5'd2);
    wait_grant(core, t0);
    chk("cont_third", 32'(core), 32'd0);
    serve(2, 32'h5555_5555);
    wait_rsp(0, t1);
    consume(0);
    set_req(0, 5'b00110, 32'h6666_6666, 32'h7777_7777, 5'd4);
    wait_grant(core, t0);
    chk("cont_fourth", 32'(core), 32'd1);
    serve(4, 32'h8888_8888);
    wait_rsp(1, t1);
    consume(1);
    wait_grant(core, t0);
    serve(1, 32'h9999_9999);
    wait_rsp(0, t1);
    consume(0);

    // Illegal op on core 1
    n_start = 0;
    set_req(1, 5'b01011, 32'hAAAA_AAAA, 32'hBBBB_BBBB, 5'd9);
    wait_grant(core, t0);
    chk("ill_grant", 32'(core), 32'd1);
    wait_rsp(1, t1);
    chk("ill_latency", 32'((t1 - t0) / 10), 32'd1);
    chk("ill_data", rsp_data, 32'h0);
    chk("ill_err", 32'(rsp_err), 32'd1);
    chk("ill_rd", 32'(rsp_rd), 32'd9);
    consume(1);
    chk("ill_starts", 32'(n_start), 32'd0);

    // Opcode boundaries
    for (int i = 0; i < 5; i++) begin
      set_req(i % 2, ops[i], 32'(i) * 32'h0101_0101, 32'hC0DE_0000 + 32'(i), 5'(20 + i));
      wait_grant(core, t0);
      if (legal(ops[i])) serve(1, 32'h1234_0000 + 32'(i));
      wait_rsp(i % 2, t1);
      chk("bound_err", 32'(rsp_err), 32'(!legal(ops[i])));
      consume(i % 2);
    end

    // Timeout, then a late done that must be ignored
    set_req(0, 5'b00011, 32'h4120_0000, 32'h0, 5'd11);
    wait_grant(core, t0);
    wait_rsp(0, t1);
    chk("to_latency", 32'((t1 - t0) / 10), 32'(TIMEOUT + 2));
    chk("to_data", rsp_data, 32'hFFFF_FFFF);
    chk("to_err", 32'(rsp_err), 32'd1);
    step(1);
    fpu_done = 1'b1; fpu_result = 32'h1234_5678;
    step(1);
    fpu_done = 1'b0;
    @(negedge clk);
    chk("to_late_done", rsp_data, 32'hFFFF_FFFF);
    consume(0);
    fpu_done = 1'b1;
    step(1);
    fpu_done = 1'b0;

    // Done on exactly the timeout cycle wins
    set_req(1, 5'b00011, 32'h4120_0000, 32'h4000_0000, 5'd14);
    wait_grant(core, t0);
    serve(TIMEOUT, 32'h40A0_0000);
    wait_rsp(1, t1);
    chk("edge_latency", 32'((t1 - t0) / 10), 32'(TIMEOUT + 2));
    chk("edge_data", rsp_data, 32'h40A0_0000);
    chk("edge_err", 32'(rsp_err), 32'd0);
    consume(1);

    // Backpressure with core 1 waiting, then reset during WAIT
    set_req(0, 5'b00001, 32'h4000_0000, 32'h4000_0000, 5'd12);
    wait_grant(core, t0);
    serve(2, 32'h4080_0000);
    wait_rsp(0, t1);
    step(1);
    set_req(1, 5'b00010, 32'h4100_0000, 32'h4110_0000, 5'd13);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_ready_1", 32'(req_ready_1), 32'd0);
      chk("bp_data", rsp_data, 32'h4080_0000);
    end
    consume(0);
    wait_grant(core, t0);
    chk("bp_next_grant", 32'(core), 32'd1);
    step(3);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    fpu_done = 1'b1; fpu_result = 32'h7777_0000;
    step(1);
    fpu_done = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("rst_no_rsp", 32'(rsp_valid_1), 32'd0);
      chk("rst_rsp_data", rsp_data, 32'h0);
      chk("rst_fpu_a", fpu_a, 32'h0);
    end
    step(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fpu_share_arbiter.md
FPU_SHARE_ARBITER -- requirements
Module: fpu_share_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 64: maximum cycles from fpu_start to fpu_done before an error is declared.
REQ-002 The block SHALL use one clock and a synchronous, active-high reset, with ports as follows.
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
REQ-003 Per-core request ports (suffix c = 0, 1):
- req_valid_c  in  1  core c presents an FPU operation
- req_ready_c  out  1  arbiter accepts core c operation this cycle
- req_op_c  in  5  FPUControl code
- req_a_c  in  32  operand A
- req_b_c  in  32  operand B
- req_rd_c  in  5  destination register tag
REQ-004 Per-core response ports:
- rsp_valid_c  out  1  result for core c pending
- rsp_ready_c  in  1  core c consumes result
REQ-005 Shared response bus:
- rsp_data  out  32  result
- rsp_rd  out  5  echoed tag
- rsp_err  out  1  illegal op or timeout
REQ-006 FPU-side ports:
- fpu_start  out  1  one-cycle launch pulse
- fpu_op  out  5  latched op
- fpu_a  out  32  latched operand A
- fpu_b  out  32  latched operand B
- fpu_done  in  1  result valid pulse
- fpu_result  in  32  FPU result

Function
REQ-007 The FSM SHALL have four states: IDLE, ISSUE, WAIT, RESP.
REQ-008 IDLE: grant to the single valid requester; if both are valid, grant the core selected by priority pointer prio (0 or 1); req_ready_c SHALL be 1 only for the granted core, only in IDLE, and is combinational.
REQ-009 On acceptance (req_valid_c & req_ready_c), the block SHALL latch op, a, b, rd and owner=c, then go to ISSUE.
REQ-010 Legal ops are 5'b00000-5'b01010 and 5'b01100-5'b10010; an illegal op (5'b01011 or 5'b10011-5'b11111) SHALL go directly to RESP with rsp_data=0 and rsp_err=1, and no fpu_start.
REQ-011 ISSUE: fpu_start=1 for exactly one cycle; clear the timeout counter; go to WAIT.
REQ-012 WAIT: the counter increments each cycle. On fpu_done, capture fpu_result, set rsp_err=0, and go to RESP. If the counter reaches TIMEOUT first, set rsp_data=32'hFFFF_FFFF and rsp_err=1, then go to RESP.
REQ-013 A fpu_done arriving in the same cycle the counter reaches TIMEOUT SHALL win: the result is captured, with err=0.
REQ-014 fpu_done SHALL be ignored outside WAIT, including a late done after a timeout.
REQ-015 RESP: rsp_valid_owner=1, the other rsp_valid=0, and rsp_data/rsp_rd/rsp_err are held stable until rsp_ready_owner=1. On that cycle, prio SHALL be set to ~owner and the FSM returns to IDLE.
REQ-016 fpu_op/fpu_a/fpu_b SHALL hold the latched values from ISSUE through the end of RESP.
REQ-017 Latency: accept at cycle N gives fpu_start at N+1; fpu_done at N+1+L gives rsp_valid at N+2+L; an illegal op gives rsp_valid at N+1.
REQ-018 A new request SHALL be accepted no earlier than the cycle after response consumption (back-to-back throughput: one op per L+3 cycles minimum).
REQ-019 A requester deasserting req_valid before grant SHALL be harmless; requests SHALL NOT be dropped once accepted.

Reset
REQ-020 While rst=1 at a clock edge, the block SHALL go to state=IDLE with prio=0, counter=0, all req_ready=0 during the reset cycle, all rsp_valid=0, fpu_start=0, rsp_data=0, rsp_rd=0, rsp_err=0, fpu_op=0, fpu_a=0, and fpu_b=0.
REQ-021 Reset asserted mid-operation (ISSUE/WAIT/RESP) SHALL abandon the operation with no response, and a subsequent fpu_done SHALL be ignored.

Verification
REQ-022 Single request: core0 FMUL (5'b00010), a=32'h40000000, b=32'h40400000, rd=5; fpu_done after 3 cycles with result=32'h40C00000 -> rsp_valid_0 at accept+5, rsp_data=32'h40C00000, rsp_rd=5, err=0, exactly one fpu_start.
REQ-023 Contention: both cores valid from reset -> core0 served first, then core1; repeat with both valid -> core0 again (prio alternates); no fpu_start overlap.
REQ-024 Illegal op: core1 req_op=5'b01011 -> no fpu_start, rsp_valid_1 next cycle, rsp_data=0, rsp_err=1.
REQ-025 Timeout: FDIV with fpu_done never asserted, TIMEOUT=64 -> rsp_err=1, rsp_data=32'hFFFF_FFFF; a later fpu_done is ignored.
REQ-026 Backpressure/reset: hold rsp_ready_0=0 for 10 cycles -> outputs stable, core1 req_ready stays 0; then assert rst in WAIT of the next op -> all outputs return to their reset values and no response is issued.
